// File: rtl/target_overlay.sv
// Target marker overlay: samples the detector's coordinates once per frame,
// smooths and tracks them, and draws a box-plus-crosshair over the VGA stream.
module target_overlay #(
  parameter int unsigned ALPHA_SHIFT = 2,
  parameter int unsigned ACQ_FRAMES  = 3,
  parameter int unsigned LOST_FRAMES = 8,
  parameter int unsigned JUMP_MAX    = 64,
  parameter int unsigned BOX_HALF    = 8,
  parameter int unsigned NO_TARGET_Y = 240
) (
  input  logic        VGA_clock,
  input  logic        reset,
  input  logic [23:0] pixel_in,
  input  logic [9:0]  x_cont,
  input  logic [8:0]  y_cont,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [8:0]  horz_line,
  input  logic [9:0]  vert_line,
  input  logic        overlay_on,
  output logic [23:0] pixel_out,
  output logic [1:0]  track_state,
  output logic [9:0]  x_smooth,
  output logic [8:0]  y_smooth
);

  typedef enum logic [1:0] {
    StSearch  = 2'd0,
    StAcquire = 2'd1,
    StTrack   = 2'd2,
    StCoast   = 2'd3
  } state_e;

  localparam logic signed [10:0] JumpMax    = 11'(JUMP_MAX);
  localparam logic signed [10:0] BoxHalf    = 11'(BOX_HALF);
  localparam logic [8:0]         NoTargetY  = 9'(NO_TARGET_Y);
  localparam logic [7:0]         AcqFrames  = 8'(ACQ_FRAMES);
  localparam logic [7:0]         LostFrames = 8'(LOST_FRAMES);

  state_e      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [7:0]  acq_q, acq_d;
  logic [7:0]  miss_q, miss_d;
  logic        vsync_q, fall_q;
  logic        strobe;
  logic [23:0] pix_q, pix_d;

  // Falling edge delayed one extra cycle so the detector's coordinates have settled.
  assign strobe = fall_q;

  logic signed [10:0] dx_s, dy_s, adx_s, ady_s, sx_s, sy_s;
  logic signed [11:0] sum_x, sum_y;
  logic [9:0]         x_new;
  logic [8:0]         y_new;
  logic               absent, near;

  assign dx_s  = $signed({1'b0, vert_line}) - $signed({1'b0, x_q});
  assign dy_s  = $signed({2'b00, horz_line}) - $signed({2'b00, y_q});
  assign adx_s = dx_s[10] ? -dx_s : dx_s;
  assign ady_s = dy_s[10] ? -dy_s : dy_s;

  assign absent = (horz_line == NoTargetY);
  assign near   = !absent && (adx_s <= JumpMax) && (ady_s <= JumpMax);

  // Arithmetic shift floors negative steps toward -infinity.
  assign sx_s  = dx_s >>> ALPHA_SHIFT;
  assign sy_s  = dy_s >>> ALPHA_SHIFT;
  assign sum_x = $signed({2'b00, x_q}) + $signed({sx_s[10], sx_s});
  assign sum_y = $signed({3'b000, y_q}) + $signed({sy_s[10], sy_s});

  always_comb begin
    x_new = sum_x[9:0];
    if (sum_x < 12'sd0)        x_new = 10'd0;
    else if (sum_x > 12'sd639) x_new = 10'd639;
    y_new = sum_y[8:0];
    if (sum_y < 12'sd0)        y_new = 9'd0;
    else if (sum_y > 12'sd479) y_new = 9'd479;
  end

  // State register
  always_ff @(posedge VGA_clock) begin
    if (reset) begin
      state_q <= StSearch;
      x_q     <= 10'd320;
      y_q     <= 9'd240;
      acq_q   <= 8'd0;
      miss_q  <= 8'd0;
      vsync_q <= 1'b0;
      fall_q  <= 1'b0;
      pix_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acq_q   <= acq_d;
      miss_q  <= miss_d;
      vsync_q <= v_sync;
      fall_q  <= vsync_q & ~v_sync;
      pix_q   <= pix_d;
    end
  end

  // Next-state logic, evaluated only at the frame strobe
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acq_d   = acq_q;
    miss_d  = miss_q;
    if (strobe) begin
      unique case (state_q)
        StSearch: begin
          if (!absent) begin
            x_d     = vert_line;
            y_d     = horz_line;
            acq_d   = 8'd1;
            state_d = (AcqFrames == 8'd1) ? StTrack : StAcquire;
          end
        end
        StAcquire: begin
          if (near) begin
            x_d   = x_new;
            y_d   = y_new;
            acq_d = acq_q + 8'd1;
            if (acq_q + 8'd1 == AcqFrames) state_d = StTrack;
          end else begin
            acq_d   = 8'd0;
            state_d = StSearch;
          end
        end
        StTrack: begin
          if (near) begin
            x_d = x_new;
            y_d = y_new;
          end else begin
            miss_d  = 8'd1;
            state_d = StCoast;
          end
        end
        StCoast: begin
          if (near) begin
            x_d     = x_new;
            y_d     = y_new;
            miss_d  = 8'd0;
            state_d = StTrack;
          end else if (miss_q + 8'd1 == LostFrames) begin
            miss_d  = 8'd0;
            state_d = StSearch;
          end else begin
            miss_d = miss_q + 8'd1;
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  logic signed [10:0] px_s, py_s, apx_s, apy_s;
  logic               mark;
  logic [23:0]        colour;

  assign px_s  = $signed({1'b0, x_cont}) - $signed({1'b0, x_q});
  assign py_s  = $signed({2'b00, y_cont}) - $signed({2'b00, y_q});
  assign apx_s = px_s[10] ? -px_s : px_s;
  assign apy_s = py_s[10] ? -py_s : py_s;

  // Output logic: box outline plus centre crosshair
  always_comb begin
    mark = ((apx_s == BoxHalf) && (apy_s <= BoxHalf)) ||
           ((apy_s == BoxHalf) && (apx_s <= BoxHalf)) ||
           ((apx_s == 11'sd0)  && (apy_s <= BoxHalf)) ||
           ((apy_s == 11'sd0)  && (apx_s <= BoxHalf));
    colour = (state_q == StTrack) ? 24'h00FF00 : 24'hFFFF00;
    pix_d  = pixel_in;
    if (overlay_on && h_sync && v_sync && mark && (state_q != StSearch)) pix_d = colour;
  end

  assign pixel_out   = pix_q;
  assign track_state = state_q;
  assign x_smooth    = x_q;
  assign y_smooth    = y_q;

endmodule
